// File: rtl/logicnet_vote_pkg.sv
// Shared parameter defaults and FSM state encoding for the ensemble vote/argmax block.
package logicnet_vote_pkg;

  localparam int NUM_CLASSES_D = 10;
  localparam int IN_W_D        = 1;
  localparam int ACC_W_D       = 4;
  localparam int CLS_W_D       = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } vote_state_e;

endpackage

// File: rtl/ens_vote_sat_acc.sv
// One per-class vote accumulator: adds an unsigned beat value, saturates at all-ones, clears on demand.
module ens_vote_sat_acc #(
  parameter int IN_W  = 1,
  parameter int ACC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  logic [IN_W-1:0]  add_val,
  output logic [ACC_W-1:0] acc
);

  // One spare bit above the wider operand so the carry is never lost before saturation.
  localparam int SUM_W = ((ACC_W > IN_W) ? ACC_W : IN_W) + 1;
  localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    sum   = SUM_W'(acc_q) + SUM_W'(add_val);
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (add_en)
      acc_d = (sum > SAT_MAX) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/ens_vote_argmax.sv
// Ensemble vote accumulation followed by a one-comparator sequential argmax scan.
module ens_vote_argmax
  import logicnet_vote_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_D,
  parameter int IN_W        = IN_W_D,
  parameter int ACC_W       = ACC_W_D,
  parameter int CLS_W       = CLS_W_D
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CLASSES*IN_W-1:0] in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CLS_W-1:0]            out_class,
  output logic [ACC_W-1:0]            out_score
);

  // Scan index runs 0..NUM_CLASSES: the extra step drains the candidate register.
  localparam int IDX_W = $clog2(NUM_CLASSES + 1);

  vote_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] cand_val_q, cand_val_d;
  logic [CLS_W-1:0] cand_idx_q, cand_idx_d;
  logic             cand_vld_q, cand_vld_d;
  logic [ACC_W-1:0] best_score_q, best_score_d;
  logic [CLS_W-1:0] best_idx_q, best_idx_d;

  logic [NUM_CLASSES-1:0][ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sel;
  logic             acc_clr, acc_add;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_acc
    ens_vote_sat_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (acc_clr),
      .add_en  (acc_add),
      .add_val (in_data[c*IN_W +: IN_W]),
      .acc     (acc[c])
    );
  end

  always_comb begin
    acc_sel = '0;
    for (int c = 0; c < NUM_CLASSES; c++)
      if (idx_q == IDX_W'(c)) acc_sel = acc[c];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cand_val_d   = cand_val_q;
    cand_idx_d   = cand_idx_q;
    cand_vld_d   = 1'b0;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    acc_clr      = 1'b0;
    acc_add      = 1'b0;
    in_ready     = (state_q == ACCUM);
    out_valid    = (state_q == OUT);
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_add = 1'b1;
          if (in_last) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
      end
      SCAN: begin
        // Stage 1: fetch acc[idx]. Stage 2: compare last fetch against best.
        if (idx_q < IDX_W'(NUM_CLASSES)) begin
          cand_vld_d = 1'b1;
          cand_val_d = acc_sel;
          cand_idx_d = CLS_W'(idx_q);
        end
        // Class 0 seeds best; later classes need strictly greater, so ties keep the lower index.
        if (cand_vld_q && (cand_idx_q == '0 || cand_val_q > best_score_q)) begin
          best_score_d = cand_val_q;
          best_idx_d   = cand_idx_q;
        end
        if (idx_q == IDX_W'(NUM_CLASSES)) begin
          state_d = OUT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          acc_clr      = 1'b1;
          best_score_d = '0;
          best_idx_d   = '0;
          state_d      = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      idx_q        <= '0;
      cand_val_q   <= '0;
      cand_idx_q   <= '0;
      cand_vld_q   <= 1'b0;
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cand_val_q   <= cand_val_d;
      cand_idx_q   <= cand_idx_d;
      cand_vld_q   <= cand_vld_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
    end
  end

  assign out_class = best_idx_q;
  assign out_score = best_score_q;

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Randomized and directed self-check of ens_vote_argmax against a vote-count reference model.
module tb_ens_vote_argmax;

  localparam int NC  = 10;
  localparam int MAXV = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_class;
  logic [3:0]    out_score;

  int n_chk  = 0;
  int n_fail = 0;
  int mdl[NC];

  ens_vote_argmax dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    for (int c = 0; c < NC; c++) mdl[c] = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic beat(input logic [NC-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    chk("in_ready_accum", int'(in_ready), 1);
    @(negedge clk);
    for (int c = 0; c < NC; c++)
      if (d[c]) mdl[c] = (mdl[c] + 1 > MAXV) ? MAXV : mdl[c] + 1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits out the scan, checks the result, holds it for `hold` cycles, then accepts it.
  task automatic finish_sample(input int hold);
    int exp_s, exp_c, n, oc, os;
    exp_s = 0;
    for (int c = 0; c < NC; c++) if (mdl[c] > exp_s) exp_s = mdl[c];
    exp_c = 0;
    for (int c = NC-1; c >= 0; c--) if (mdl[c] == exp_s) exp_c = c;
    n = 0;
    chk("in_ready_scan", int'(in_ready), 0);
    while (!out_valid && n < 40) begin
      // Garbage on the input side must be ignored outside ACCUM.
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      in_data  = NC'($urandom);
      @(negedge clk);
      n++;
    end
    chk("latency", n, NC + 1);
    chk("out_class", int'(out_class), exp_c);
    chk("out_score", int'(out_score), exp_s);
    oc = out_class;
    os = out_score;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      in_data  = NC'($urandom);
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_class", int'(out_class), oc);
      chk("hold_score", int'(out_score), os);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", int'(out_valid), 0);
    chk("post_hs_in_ready", int'(in_ready), 1);
    mdl_clear();
  endtask

  initial begin
    logic [NC-1:0] d;
    int nb;
    mdl_clear();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_class", int'(out_class), 0);
    chk("rst_score", int'(out_score), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);

    // Single class-3 vote.
    beat(10'b0000001000, 1'b1); finish_sample(0);
    // {2,5},{5},{2,5}
    beat(10'b0000100100, 1'b0); beat(10'b0000100000, 1'b0);
    beat(10'b0000100100, 1'b1); finish_sample(1);
    // Tie between 4 and 7, then all-zero sample.
    beat(10'b0010010000, 1'b1); finish_sample(0);
    beat(10'b0000000000, 1'b1); finish_sample(0);
    // Saturation.
    for (int i = 0; i < 20; i++) beat('1, (i == 19));
    finish_sample(0);
    // Back-pressure, then a fresh sample proves the clear.
    beat(10'b0001000000, 1'b1); finish_sample(5);
    beat(10'b1000000000, 1'b1); finish_sample(0);

    // Reset during SCAN at idx 4.
    beat(10'b0000011000, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    @(negedge clk);
    chk("after_rst_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("after_rst_no_out", int'(out_valid), 0);
    end
    beat(10'b0001000000, 1'b1); finish_sample(0);

    // Random samples.
    for (int s = 0; s < 30; s++) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        d = NC'($urandom);
        if ($urandom_range(0, 5) == 0) d = '1;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        beat(d, (b == nb - 1));
      end
      finish_sample($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ens_vote_argmax.md
ENS_VOTE_ARGMAX -- requirements
Module: ens_vote_argmax

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 10: number of output classes, one final-layer neuron bit per class per ensemble member.
REQ-002 The block SHALL have parameter IN_W, default 1: width of each per-class neuron output.
REQ-003 The block SHALL have parameter ACC_W, default 4: width of each per-class saturating vote accumulator.
REQ-004 The block SHALL have parameter CLS_W, default 4: width of the class index, at least clog2(NUM_CLASSES).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port in_data, input, NUM_CLASSES*IN_W bits: class c occupies bits [c*IN_W +: IN_W]; unsigned.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data and in_last valid.
REQ-009 The block SHALL have port in_last, input, 1 bit: final ensemble member of the current sample.
REQ-010 The block SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port out_class, output, CLS_W bits: winning class index.
REQ-014 The block SHALL have port out_score, output, ACC_W bits: accumulated vote count of the winning class.

Function
REQ-015 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1; out_valid and out_ready SHALL be handled the same way.
REQ-016 The FSM SHALL have three states: ACCUM, SCAN and OUT; in_ready SHALL be 1 only in ACCUM, and out_valid SHALL be 1 only in OUT.
REQ-017 On each accepted beat, every acc[c] SHALL become min(acc[c] + in_data[c], 2^ACC_W - 1), with no wrap-around.
REQ-018 An accepted beat with in_last=1 SHALL move ACCUM to SCAN; with in_last=0 the FSM SHALL stay in ACCUM.
REQ-019 SCAN SHALL examine one class per cycle, idx 0 to NUM_CLASSES-1; best starts at class 0; a later class replaces best only if strictly greater, so a tie goes to the lowest index.
REQ-020 After idx NUM_CLASSES-1 the FSM SHALL enter OUT; out_valid SHALL rise exactly NUM_CLASSES+1 cycles after the in_last handshake.
REQ-021 In OUT, out_class and out_score SHALL stay stable until the output handshake.
REQ-022 On the output handshake, all acc SHALL clear to 0, out_valid SHALL fall, and the FSM SHALL return to ACCUM, with in_ready=1 in the next cycle.
REQ-023 in_data, in_last and in_valid SHALL be ignored outside ACCUM; there is no simultaneous accept and emit.
REQ-024 When all accumulators are 0 the result SHALL be out_class=0 and out_score=0.

Reset
REQ-025 When rst_n=0 the block SHALL go, asynchronously, to: state ACCUM, all acc 0, scan index 0, out_valid 0, out_class 0, out_score 0.
REQ-026 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-027 Reset in any state, including mid-SCAN or in OUT with an unaccepted result, SHALL discard the partial sample with no output emitted.

Structure
REQ-028 The parameter defaults and the state enum (ACCUM, SCAN, OUT) SHALL live in the shared package logicnet_vote_pkg.
REQ-029 A single sub-module ens_vote_sat_acc SHALL implement one per-class saturating accumulator with clear, instantiated NUM_CLASSES times.
REQ-030 The argmax datapath SHALL be sequential (one comparator), not a NUM_CLASSES-wide combinational tree.

Verification
REQ-031 Single beat, in_data=10'b0000001000 (class 3), in_last=1 -> out_class=3, out_score=1, out_valid exactly 11 cycles after the handshake.
REQ-032 Beats {2,5}, {5}, then {2,5} with in_last=1 -> out_class=5, out_score=3.
REQ-033 Single beat with classes 4 and 7 set -> out_class=4 (tie rule); single all-zero beat -> out_class=0, out_score=0.
REQ-034 20 beats of all-ones, last with in_last=1 -> every acc saturates at 15; out_class=0, out_score=15.
REQ-035 out_ready held 0 for 5 cycles in OUT -> outputs stable and in_ready=0 throughout; after the handshake, next sample {9} -> out_class=9, out_score=1 (accumulators were cleared).
REQ-036 rst_n pulsed low at SCAN idx 4 -> out_valid stays 0, in_ready=1 the cycle after release, next sample {6} -> out_class=6.
